kamus_ctrl_seq: RTL and testbench

Multi-cycle, parametrised control sequencer for the kamus-v core; the sequential successor to the single-cycle control decode. It sits between the decoder and the datapath/L1D port. It issues regfile write and writeback-select controls, the next-PC mode and L1D request/write strobes. It adds a valid/ready instruction handshake, a stalled L1D request/response protocol, a configurable post-redirect flush window and a trap state for illegal ops and memory timeouts.

---
 rtl/kamus_ctrl_seq.sv | 170 +++++++++++++++++
 tb/tb_kamus_ctrl_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/kamus_ctrl_seq.sv
// kamus_ctrl_seq: multi-cycle control sequencer between decoder and datapath/L1D port
//   clk_i, rst_i (sync, active-high)      clock and reset
//   valid_i, op_class_i, br_taken_i       decoded instruction handshake and class
//   ready_o                               instruction accepted this cycle when valid_i
//   instr_addr_state_o                    next-PC mode (PC/B/J/HOLD)
//   wb_sel_o, regfile_wr_en_o             writeback select and regfile write strobe
//   stall_o, flush_o                      freeze fetch/decode, kill younger instructions
//   l1d_req_o, l1d_we_o, l1d_gnt_i,
//   l1d_rvalid_i                          L1D request/response
//   trap_clr_i, err_o                     leave TRAP, TRAP indicator
//   Optional: define KAMUS_CU_TIMEOUT_EN to enable the L1D timeout counter and MEM->TRAP path.
module kamus_ctrl_seq #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [2:0] op_class_i,
    input  logic       br_taken_i,
    output logic       ready_o,
    output logic [1:0] instr_addr_state_o,
    output logic [1:0] wb_sel_o,
    output logic       regfile_wr_en_o,
    output logic       stall_o,
    output logic       flush_o,
    output logic       l1d_req_o,
    output logic       l1d_we_o,
    input  logic       l1d_gnt_i,
    input  logic       l1d_rvalid_i,
    input  logic       trap_clr_i,
    output logic       err_o
);
    typedef enum logic [2:0] {EXEC, MEM_REQ, MEM_WAIT, FLUSH, TRAP} state_e;
    localparam logic [1:0] PC_ST = 2'd0, B_ST = 2'd1, J_ST = 2'd2, HOLD_ST = 2'd3;
    localparam logic [1:0] ALU_RESULT = 2'd0, MEM_RESULT = 2'd1, PC_PLUS4 = 2'd2;
    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

    state_e     state_q, state_d;
    logic       is_store_q, is_store_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       tmo;
    logic       done;

`ifdef KAMUS_CU_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
    // Counts cycles spent in MEM_REQ/MEM_WAIT; it is zero on every entry from EXEC.
    always_ff @(posedge clk_i) begin
        if (rst_i) tcnt_q <= '0;
        else tcnt_q <= (state_q == MEM_REQ || state_q == MEM_WAIT) ? tcnt_q + 1'b1 : '0;
    end
    // Asserted in the cycle whose increment makes the counter reach MEM_TIMEOUT.
    assign tmo = (state_q == MEM_REQ || state_q == MEM_WAIT) && (tcnt_q == TW'(MEM_TIMEOUT - 1));
`else
    // Without the timeout feature memory accesses wait indefinitely.
    assign tmo = (MEM_TIMEOUT == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EXEC;
            is_store_q <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        is_store_d         = is_store_q;
        fcnt_d             = fcnt_q;
        done               = 1'b0;
        ready_o            = 1'b0;
        instr_addr_state_o = PC_ST;
        wb_sel_o           = ALU_RESULT;
        regfile_wr_en_o    = 1'b0;
        stall_o            = 1'b0;
        flush_o            = 1'b0;
        l1d_req_o          = 1'b0;
        l1d_we_o           = 1'b0;
        err_o              = 1'b0;
        case (state_q)
            EXEC: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    case (op_class_i)
                        3'd0: regfile_wr_en_o = 1'b1;
                        3'd1, 3'd2: begin
                            stall_o            = 1'b1;
                            instr_addr_state_o = HOLD_ST;
                            is_store_d         = (op_class_i == 3'd2);
                            state_d            = MEM_REQ;
                        end
                        3'd3: begin
                            if (br_taken_i) begin
                                instr_addr_state_o = B_ST;
                                fcnt_d             = FC;
                                state_d            = (FC == 4'd0) ? EXEC : FLUSH;
                            end
                        end
                        3'd4: begin
                            regfile_wr_en_o    = 1'b1;
                            wb_sel_o           = PC_PLUS4;
                            instr_addr_state_o = J_ST;
                            fcnt_d             = FC;
                            state_d            = (FC == 4'd0) ? EXEC : FLUSH;
                        end
                        default: begin
                            instr_addr_state_o = HOLD_ST;
                            state_d            = TRAP;
                        end
                    endcase
                end
            end
            MEM_REQ: begin
                l1d_req_o          = 1'b1;
                l1d_we_o           = is_store_q;
                stall_o            = 1'b1;
                instr_addr_state_o = HOLD_ST;
                if (l1d_gnt_i) begin
                    done            = is_store_q || l1d_rvalid_i;
                    regfile_wr_en_o = !is_store_q && l1d_rvalid_i;
                    wb_sel_o        = (!is_store_q && l1d_rvalid_i) ? MEM_RESULT : ALU_RESULT;
                    state_d         = done ? EXEC : MEM_WAIT;
                end
                // A completion in the timeout cycle retires instead of trapping.
                if (tmo && !done) state_d = TRAP;
            end
            MEM_WAIT: begin
                stall_o            = 1'b1;
                instr_addr_state_o = HOLD_ST;
                if (l1d_rvalid_i) begin
                    done            = 1'b1;
                    regfile_wr_en_o = 1'b1;
                    wb_sel_o        = MEM_RESULT;
                    state_d         = EXEC;
                end else if (tmo) begin
                    state_d = TRAP;
                end
            end
            FLUSH: begin
                flush_o = 1'b1;
                fcnt_d  = fcnt_q - 1'b1;
                if (fcnt_q <= 4'd1) state_d = EXEC;
            end
            TRAP: begin
                err_o              = 1'b1;
                instr_addr_state_o = HOLD_ST;
                if (trap_clr_i) state_d = EXEC;
            end
            default: state_d = EXEC;
        endcase
        // Outputs are forced quiet during reset so no L1D request or write leaks out.
        if (rst_i) begin
            ready_o            = 1'b0;
            instr_addr_state_o = HOLD_ST;
            wb_sel_o           = ALU_RESULT;
            regfile_wr_en_o    = 1'b0;
            stall_o            = 1'b0;
            flush_o            = 1'b0;
            l1d_req_o          = 1'b0;
            l1d_we_o           = 1'b0;
            err_o              = 1'b0;
        end
    end
endmodule

// File: tb/tb_kamus_ctrl_seq.sv
// tb_kamus_ctrl_seq: randomized and directed check of kamus_ctrl_seq against a behavioural model
module tb_kamus_ctrl_seq;
    localparam int FC = 2;
    localparam int MT = 4;
`ifdef KAMUS_CU_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, valid = 1'b0, br = 1'b0, gnt = 1'b0, rv = 1'b0, clr = 1'b0;
    logic [2:0] op = 3'd0;
    logic       ready, wr, stall, flush, req, we, err;
    logic [1:0] ias, wb;

    int total = 0;
    int bad   = 0;
    int n_stall, n_req, n_wr, n_flush, n_err;

    int flush_left = 0;
    int mem_cycles = 0;
    bit in_mem = 0, granted = 0, is_st = 0, trapped = 0;

    always #5 clk = ~clk;

    kamus_ctrl_seq #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_class_i(op), .br_taken_i(br),
        .ready_o(ready), .instr_addr_state_o(ias), .wb_sel_o(wb), .regfile_wr_en_o(wr),
        .stall_o(stall), .flush_o(flush), .l1d_req_o(req), .l1d_we_o(we),
        .l1d_gnt_i(gnt), .l1d_rvalid_i(rv), .trap_clr_i(clr), .err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_stats();
        n_stall = 0; n_req = 0; n_wr = 0; n_flush = 0; n_err = 0;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [2:0] o, input bit b,
                       input bit g, input bit rvl, input bit c);
        bit er, ewr, est, efl, erq, ewe, eer, done;
        logic [1:0] eia, ewb;
        @(negedge clk);
        rst = r; valid = v; op = o; br = b; gnt = g; rv = rvl; clr = c;
        #1;
        er = 0; ewr = 0; est = 0; efl = 0; erq = 0; ewe = 0; eer = 0; eia = 0; ewb = 0;
        if (r) begin
            eia = 3; flush_left = 0; in_mem = 0; trapped = 0;
        end else if (trapped) begin
            eer = 1; eia = 3;
            if (c) trapped = 0;
        end else if (flush_left > 0) begin
            efl = 1; flush_left--;
        end else if (in_mem) begin
            est = 1; eia = 3; erq = !granted; ewe = erq && is_st;
            done = granted ? rvl : (g && (is_st || rvl));
            if (done && !is_st) begin ewr = 1; ewb = 1; end
            mem_cycles++;
            if (done) in_mem = 0;
            else begin
                if (g) granted = 1;
                if (TMO_EN && mem_cycles >= MT) begin in_mem = 0; trapped = 1; end
            end
        end else begin
            er = 1;
            if (v) begin
                case (o)
                    3'd0: ewr = 1;
                    3'd1, 3'd2: begin
                        est = 1; eia = 3; in_mem = 1; granted = 0; is_st = (o == 3'd2); mem_cycles = 0;
                    end
                    3'd3: if (b) begin eia = 1; flush_left = FC; end
                    3'd4: begin ewr = 1; ewb = 2; eia = 2; flush_left = FC; end
                    default: begin eia = 3; trapped = 1; end
                endcase
            end
        end
        chk("outs{rdy,ias,wb,wr,stl,fl,req,we,err}",
            {21'd0, ready, ias, wb, wr, stall, flush, req, we, err},
            {21'd0, er, eia, ewb, ewr, est, efl, erq, ewe, eer});
        n_stall += int'(stall); n_req += int'(req); n_wr += int'(wr);
        n_flush += int'(flush); n_err += int'(err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 3'd0, 0, 0, 0, 0);
        cyc(1, 0, 3'd0, 0, 0, 0, 0);
        cyc(0, 1, 3'd0, 0, 0, 0, 0);
        chk("alu_ready", ready, 1'b1);
        chk("alu_wr", wr, 1'b1);

        clr_stats();
        cyc(0, 1, 3'd1, 0, 0, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 0, 0);
        cyc(0, 0, 3'd0, 0, 1, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 1, 0);
        chk("ld_wb_sel", wb, 2'd1);
        chk("ld_stall_cycles", n_stall, 4);
        chk("ld_req_cycles", n_req, 2);
        chk("ld_wr_count", n_wr, 1);

        clr_stats();
        cyc(0, 1, 3'd2, 0, 0, 0, 0);
        cyc(0, 0, 3'd0, 0, 1, 0, 0);
        chk("st_we", we, 1'b1);
        cyc(0, 0, 3'd0, 0, 0, 0, 0);
        chk("st_ready_after", ready, 1'b1);
        chk("st_wr_count", n_wr, 0);

        clr_stats();
        cyc(0, 1, 3'd3, 1, 0, 0, 0);
        chk("br_ias", ias, 2'd1);
        idle(3);
        chk("br_flush_cycles", n_flush, FC);
        chk("br_ready_after", ready, 1'b1);

        clr_stats();
        cyc(0, 1, 3'd4, 0, 0, 0, 0);
        chk("jmp_wb_sel", wb, 2'd2);
        chk("jmp_ias", ias, 2'd2);
        idle(3);
        chk("jmp_flush_cycles", n_flush, FC);

        clr_stats();
        cyc(0, 1, 3'd1, 0, 0, 0, 0);
        idle(6);
        chk("tmo_err_cycles", n_err, TMO_EN ? 2 : 0);
        cyc(0, 0, 3'd0, 0, 0, 0, 1);
        cyc(0, 0, 3'd0, 0, 1, 1, 0);
        idle(1);
        chk("tmo_recovered_ready", ready, 1'b1);

        cyc(0, 1, 3'd6, 0, 0, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 0, 0);
        chk("illegal_err", err, 1'b1);
        cyc(0, 0, 3'd0, 0, 0, 0, 1);
        cyc(0, 0, 3'd0, 0, 0, 0, 0);
        chk("trap_clr_ready", ready, 1'b1);

        clr_stats();
        cyc(0, 1, 3'd1, 0, 0, 0, 0);
        cyc(0, 0, 3'd0, 0, 1, 0, 0);
        cyc(1, 0, 3'd0, 0, 0, 0, 0);
        chk("rst_req_low", req, 1'b0);
        chk("rst_ias_hold", ias, 2'd3);
        cyc(0, 0, 3'd0, 0, 0, 1, 0);
        chk("late_rvalid_wr", n_wr, 0);

        for (int i = 0; i < 4000; i++) begin
            logic [2:0] o;
            o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, o, 1'($urandom),
                1'($urandom), $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
